// File: rtl/streaming_dwc.sv
// AXI-Stream width converter for the output of a StreamingFIFO stage.
// It packs narrow beats LSB-first into wide words, or unpacks wide words into narrow beats.
module streaming_dwc #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
    input  logic                 in0_V_V_TVALID,
    output logic                 in0_V_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
    output logic                 out_V_V_TVALID,
    input  logic                 out_V_V_TREADY,
    output logic [15:0]          count
);
    logic in_fire;
    logic out_fire;

    assign in_fire  = in0_V_V_TVALID & in0_V_V_TREADY;
    assign out_fire = out_V_V_TVALID & out_V_V_TREADY;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            count <= '0;
        end else if (out_fire) begin
            count <= count + 16'd1;
        end
    end

    generate
        if (OUT_WIDTH > IN_WIDTH && (OUT_WIDTH % IN_WIDTH) == 0) begin : g_up
            localparam int R  = OUT_WIDTH / IN_WIDTH;
            localparam int SW = $clog2(R);
            localparam logic [SW-1:0] LAST = SW'(R - 1);

            logic [SW-1:0]             slot;
            logic [(R-1)*IN_WIDTH-1:0] acc;

            // A completed word may be loaded in the same cycle the previous one leaves.
            assign in0_V_V_TREADY = !ap_rst && (!out_V_V_TVALID || out_V_V_TREADY);

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    slot           <= '0;
                    acc            <= '0;
                    out_V_V_TDATA  <= '0;
                    out_V_V_TVALID <= 1'b0;
                end else begin
                    if (out_fire) begin
                        out_V_V_TVALID <= 1'b0;
                    end
                    if (in_fire) begin
                        if (slot == LAST) begin
                            out_V_V_TDATA  <= {in0_V_V_TDATA, acc};
                            out_V_V_TVALID <= 1'b1;
                            slot           <= '0;
                        end else begin
                            acc[slot*IN_WIDTH +: IN_WIDTH] <= in0_V_V_TDATA;
                            slot <= slot + SW'(1);
                        end
                    end
                end
            end
        end else if (IN_WIDTH > OUT_WIDTH && (IN_WIDTH % OUT_WIDTH) == 0) begin : g_down
            localparam int R  = IN_WIDTH / OUT_WIDTH;
            localparam int SW = $clog2(R);
            localparam logic [SW-1:0] LAST = SW'(R - 1);

            logic [SW-1:0]       slot;
            logic [SW-1:0]       slot_next;
            logic [IN_WIDTH-1:0] hold;

            assign slot_next = slot + SW'(1);
            // A new word is only taken as the last slice of the held word leaves, so no bubble appears.
            assign in0_V_V_TREADY = !ap_rst &&
                                    (!out_V_V_TVALID || (out_V_V_TREADY && slot == LAST));

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    slot           <= '0;
                    hold           <= '0;
                    out_V_V_TDATA  <= '0;
                    out_V_V_TVALID <= 1'b0;
                end else if (in_fire) begin
                    hold           <= in0_V_V_TDATA;
                    out_V_V_TDATA  <= in0_V_V_TDATA[OUT_WIDTH-1:0];
                    out_V_V_TVALID <= 1'b1;
                    slot           <= '0;
                end else if (out_fire) begin
                    if (slot == LAST) begin
                        out_V_V_TVALID <= 1'b0;
                    end else begin
                        slot          <= slot_next;
                        out_V_V_TDATA <= hold[slot_next*OUT_WIDTH +: OUT_WIDTH];
                    end
                end
            end
        end else if (IN_WIDTH == OUT_WIDTH) begin : g_pass
            assign in0_V_V_TREADY = !ap_rst && (!out_V_V_TVALID || out_V_V_TREADY);

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    out_V_V_TDATA  <= '0;
                    out_V_V_TVALID <= 1'b0;
                end else begin
                    if (out_fire) begin
                        out_V_V_TVALID <= 1'b0;
                    end
                    if (in_fire) begin
                        out_V_V_TDATA  <= in0_V_V_TDATA;
                        out_V_V_TVALID <= 1'b1;
                    end
                end
            end
        end else begin : g_bad
            $error("streaming_dwc: IN_WIDTH and OUT_WIDTH must divide one another");
            assign in0_V_V_TREADY = 1'b0;
            assign out_V_V_TDATA  = '0;
            assign out_V_V_TVALID = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_streaming_dwc.sv
// Bench for streaming_dwc: an 8->32 upsizer and a 32->8 downsizer, with directed and random traffic
// checked against a byte-queue model of the stream.
module tb_streaming_dwc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  up_in_data;
    logic        up_in_valid, up_in_ready;
    logic [31:0] up_out_data;
    logic        up_out_valid, up_out_ready;
    logic [15:0] up_count;

    logic [31:0] dn_in_data;
    logic        dn_in_valid, dn_in_ready;
    logic [7:0]  dn_out_data;
    logic        dn_out_valid, dn_out_ready;
    logic [15:0] dn_count;

    int checks = 0;
    int failures = 0;

    streaming_dwc #(.IN_WIDTH(8), .OUT_WIDTH(32)) dut_up (
        .ap_clk(clk), .ap_rst(rst),
        .in0_V_V_TDATA(up_in_data), .in0_V_V_TVALID(up_in_valid), .in0_V_V_TREADY(up_in_ready),
        .out_V_V_TDATA(up_out_data), .out_V_V_TVALID(up_out_valid), .out_V_V_TREADY(up_out_ready),
        .count(up_count)
    );

    streaming_dwc #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut_dn (
        .ap_clk(clk), .ap_rst(rst),
        .in0_V_V_TDATA(dn_in_data), .in0_V_V_TVALID(dn_in_valid), .in0_V_V_TREADY(dn_in_ready),
        .out_V_V_TDATA(dn_out_data), .out_V_V_TVALID(dn_out_valid), .out_V_V_TREADY(dn_out_ready),
        .count(dn_count)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        up_in_valid = 1'b0; up_out_ready = 1'b0;
        dn_in_valid = 1'b0; dn_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one upsizer input beat; returns just after the negedge preceding its accepting edge.
    task automatic up_beat(input logic [7:0] d);
        int n;
        @(negedge clk);
        up_in_data = d;
        up_in_valid = 1'b1;
        #1;
        n = 0;
        while (!up_in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n >= 50) begin
            failures++; $display("FAIL up_beat_accept got=stalled exp=accepted data=%h", d);
        end
    endtask

    task automatic dn_beat(input logic [31:0] d);
        int n;
        @(negedge clk);
        dn_in_data = d;
        dn_in_valid = 1'b1;
        #1;
        n = 0;
        while (!dn_in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n >= 50) begin
            failures++; $display("FAIL dn_beat_accept got=stalled exp=accepted data=%h", d);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (up_out_valid !== 1'b0) begin failures++; $display("FAIL reset_up_valid got=%b exp=0", up_out_valid); end
        checks++; if (up_out_data !== 32'h0) begin failures++; $display("FAIL reset_up_data got=%h exp=0", up_out_data); end
        checks++; if (up_in_ready !== 1'b0) begin failures++; $display("FAIL reset_up_in_ready got=%b exp=0", up_in_ready); end
        checks++; if (up_count !== 16'h0) begin failures++; $display("FAIL reset_up_count got=%h exp=0", up_count); end
        checks++; if (dn_out_valid !== 1'b0) begin failures++; $display("FAIL reset_dn_valid got=%b exp=0", dn_out_valid); end
        checks++; if (dn_out_data !== 8'h0) begin failures++; $display("FAIL reset_dn_data got=%h exp=0", dn_out_data); end
        checks++; if (dn_in_ready !== 1'b0) begin failures++; $display("FAIL reset_dn_in_ready got=%b exp=0", dn_in_ready); end
        checks++; if (dn_count !== 16'h0) begin failures++; $display("FAIL reset_dn_count got=%h exp=0", dn_count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (up_in_ready !== 1'b1) begin failures++; $display("FAIL release_up_in_ready got=%b exp=1", up_in_ready); end
        checks++; if (dn_in_ready !== 1'b1) begin failures++; $display("FAIL release_dn_in_ready got=%b exp=1", dn_in_ready); end
    endtask

    task automatic test_upsize_basic();
        do_reset();
        up_out_ready = 1'b1;
        up_beat(8'h11); up_beat(8'h22); up_beat(8'h33); up_beat(8'h44);
        checks++; if (up_out_valid !== 1'b0) begin failures++; $display("FAIL up_basic_early got=%b exp=0", up_out_valid); end
        @(negedge clk);
        up_in_valid = 1'b0;
        #1;
        checks++; if (up_out_valid !== 1'b1) begin failures++; $display("FAIL up_basic_valid got=%b exp=1", up_out_valid); end
        checks++; if (up_out_data !== 32'h44332211) begin failures++; $display("FAIL up_basic_data got=%h exp=44332211", up_out_data); end
        @(negedge clk); #1;
        checks++; if (up_out_valid !== 1'b0) begin failures++; $display("FAIL up_basic_drop got=%b exp=0", up_out_valid); end
        checks++; if (up_count !== 16'd1) begin failures++; $display("FAIL up_basic_count got=%0d exp=1", up_count); end
    endtask

    task automatic test_up_backpressure();
        do_reset();
        up_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) up_beat(8'(i));
        @(negedge clk);
        up_in_data = 8'h05;
        up_in_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (up_in_ready !== 1'b0 || up_out_valid !== 1'b1 || up_out_data !== 32'h04030201) begin
                failures++;
                $display("FAIL up_stall cycle=%0d got ready=%b valid=%b data=%h exp ready=0 valid=1 data=04030201",
                         c, up_in_ready, up_out_valid, up_out_data);
            end
            if (c < 4) begin @(negedge clk); #1; end
        end
        @(negedge clk);
        up_out_ready = 1'b1;
        #1;
        checks++; if (up_in_ready !== 1'b1) begin failures++; $display("FAIL up_unstall_ready got=%b exp=1", up_in_ready); end
        up_beat(8'h06); up_beat(8'h07); up_beat(8'h08);
        @(negedge clk);
        up_in_valid = 1'b0;
        #1;
        checks++; if (up_out_valid !== 1'b1 || up_out_data !== 32'h08070605) begin
            failures++; $display("FAIL up_bp_word2 got valid=%b data=%h exp valid=1 data=08070605", up_out_valid, up_out_data);
        end
        checks++; if (up_count !== 16'd1) begin failures++; $display("FAIL up_bp_count1 got=%0d exp=1", up_count); end
        @(negedge clk); #1;
        checks++; if (up_count !== 16'd2) begin failures++; $display("FAIL up_bp_count2 got=%0d exp=2", up_count); end
    endtask

    task automatic test_reset_midword();
        up_out_ready = 1'b1;
        up_beat(8'hAA); up_beat(8'hBB);
        @(negedge clk);
        up_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (up_out_valid !== 1'b0 || up_out_data !== 32'h0) begin
            failures++; $display("FAIL async_reset_out got valid=%b data=%h exp valid=0 data=0", up_out_valid, up_out_data);
        end
        checks++; if (up_count !== 16'h0 || up_in_ready !== 1'b0) begin
            failures++; $display("FAIL async_reset_ctrl got count=%0d ready=%b exp count=0 ready=0", up_count, up_in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) up_beat(8'(i));
        @(negedge clk);
        up_in_valid = 1'b0;
        #1;
        checks++; if (up_out_valid !== 1'b1 || up_out_data !== 32'h04030201) begin
            failures++; $display("FAIL midword_first got valid=%b data=%h exp valid=1 data=04030201", up_out_valid, up_out_data);
        end
        checks++; if (up_count !== 16'd0) begin failures++; $display("FAIL midword_count0 got=%0d exp=0", up_count); end
        @(negedge clk); #1;
        checks++; if (up_count !== 16'd1) begin failures++; $display("FAIL midword_count1 got=%0d exp=1", up_count); end
    endtask

    task automatic test_downsize_basic();
        logic [7:0] exp_b [8];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
        do_reset();
        dn_out_ready = 1'b1;
        fork
            begin
                dn_beat(32'hDEADBEEF);
                dn_beat(32'h01020304);
                @(negedge clk);
                dn_in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                @(negedge clk); #1;
                while (!dn_out_valid && n < 20) begin @(negedge clk); #1; n++; end
                checks++;
                if (n >= 20) begin failures++; $display("FAIL dn_basic_start got=idle exp=valid"); end
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (dn_out_valid !== 1'b1 || dn_out_data !== exp_b[i]) begin
                        failures++;
                        $display("FAIL dn_basic_beat%0d got valid=%b data=%h exp valid=1 data=%h",
                                 i, dn_out_valid, dn_out_data, exp_b[i]);
                    end
                    @(negedge clk); #1;
                end
                checks++;
                if (dn_out_valid !== 1'b0 || dn_count !== 16'd8) begin
                    failures++; $display("FAIL dn_basic_end got valid=%b count=%0d exp valid=0 count=8", dn_out_valid, dn_count);
                end
            end
        join
    endtask

    task automatic test_random_up();
        logic [7:0]  q[$];
        logic [31:0] exp_w, prev_data;
        logic        prev_stall;
        int words, sent, cyc;
        words = 0; sent = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (words < 1000 && cyc < 40000) begin
            @(negedge clk);
            up_in_valid  = (sent < 4000) && ($urandom_range(1) == 1);
            up_in_data   = 8'($urandom);
            up_out_ready = ($urandom_range(1) == 1);
            #1;
            if (prev_stall) begin
                checks++;
                if (up_out_valid !== 1'b1 || up_out_data !== prev_data) begin
                    failures++; $display("FAIL rnd_up_hold got valid=%b data=%h exp valid=1 data=%h", up_out_valid, up_out_data, prev_data);
                end
            end
            if (up_out_valid && up_out_ready) begin
                checks++;
                if (q.size() < 4) begin
                    failures++; $display("FAIL rnd_up_early got data=%h exp=incomplete word (%0d bytes)", up_out_data, q.size());
                end else begin
                    exp_w = {q[3], q[2], q[1], q[0]};
                    repeat (4) void'(q.pop_front());
                    if (up_out_data !== exp_w) begin
                        failures++; $display("FAIL rnd_up_word%0d got=%h exp=%h", words, up_out_data, exp_w);
                    end
                end
                words++;
            end
            if (up_in_valid && up_in_ready) begin
                q.push_back(up_in_data);
                sent++;
            end
            prev_stall = up_out_valid && !up_out_ready;
            prev_data  = up_out_data;
            cyc++;
        end
        @(negedge clk);
        up_in_valid = 1'b0;
        #1;
        checks++; if (words != 1000 || q.size() != 0) begin
            failures++; $display("FAIL rnd_up_total got words=%0d left=%0d exp words=1000 left=0", words, q.size());
        end
        checks++; if (up_count !== 16'(words)) begin failures++; $display("FAIL rnd_up_count got=%0d exp=%0d", up_count, words % 65536); end
    endtask

    task automatic test_random_dn();
        logic [7:0]  q[$];
        logic [7:0]  exp_b, prev_data;
        logic        prev_stall;
        int beats, sent, cyc;
        beats = 0; sent = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (beats < 4000 && cyc < 40000) begin
            @(negedge clk);
            dn_in_valid  = (sent < 1000) && ($urandom_range(1) == 1);
            dn_in_data   = $urandom;
            dn_out_ready = ($urandom_range(1) == 1);
            #1;
            if (prev_stall) begin
                checks++;
                if (dn_out_valid !== 1'b1 || dn_out_data !== prev_data) begin
                    failures++; $display("FAIL rnd_dn_hold got valid=%b data=%h exp valid=1 data=%h", dn_out_valid, dn_out_data, prev_data);
                end
            end
            if (dn_out_valid && dn_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_dn_extra got data=%h exp=no beat", dn_out_data);
                end else begin
                    exp_b = q.pop_front();
                    if (dn_out_data !== exp_b) begin
                        failures++; $display("FAIL rnd_dn_beat%0d got=%h exp=%h", beats, dn_out_data, exp_b);
                    end
                end
                beats++;
            end
            if (dn_in_valid && dn_in_ready) begin
                for (int i = 0; i < 4; i++) q.push_back(dn_in_data[8*i +: 8]);
                sent++;
            end
            prev_stall = dn_out_valid && !dn_out_ready;
            prev_data  = dn_out_data;
            cyc++;
        end
        @(negedge clk);
        dn_in_valid = 1'b0;
        #1;
        checks++; if (beats != 4000 || q.size() != 0) begin
            failures++; $display("FAIL rnd_dn_total got beats=%0d left=%0d exp beats=4000 left=0", beats, q.size());
        end
        checks++; if (dn_count !== 16'(beats)) begin failures++; $display("FAIL rnd_dn_count got=%0d exp=%0d", dn_count, beats % 65536); end
    endtask

    task automatic test_counter_wrap();
        int n, cyc;
        n = 0; cyc = 0;
        do_reset();
        dn_out_ready = 1'b1;
        dn_in_valid = 1'b1;
        while (n < 65538 && cyc < 70000) begin
            @(negedge clk);
            dn_in_data = $urandom;
            #1;
            if (n == 65535 || n == 65536 || n == 65537) begin
                checks++;
                if (dn_count !== 16'(n)) begin
                    failures++; $display("FAIL wrap_count after=%0d got=%h exp=%h", n, dn_count, 16'(n));
                end
            end
            if (dn_out_valid && dn_out_ready) n++;
            cyc++;
        end
        dn_in_valid = 1'b0;
        checks++; if (n < 65538) begin failures++; $display("FAIL wrap_progress got=%0d exp=65538", n); end
    endtask

    initial begin
        rst = 1'b1;
        up_in_data = '0; up_in_valid = 1'b0; up_out_ready = 1'b0;
        dn_in_data = '0; dn_in_valid = 1'b0; dn_out_ready = 1'b0;
        test_reset();
        test_upsize_basic();
        test_up_backpressure();
        test_reset_midword();
        test_downsize_basic();
        do_reset();
        fork
            test_random_up();
            test_random_dn();
        join
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
